// File: rtl/qdec_cabac_package.sv
`default_nettype none
// ============================================================================
// Module   : qdec_cabac_package
// Brief    : Shared constants and helpers for the CABAC slice-data front end
// Revision : 1.0 - emulation-prevention constants and zero-run helper
// ============================================================================
package qdec_cabac_package;

    // Emulation-prevention byte and the zero-run length that makes it droppable
    localparam logic [7:0] EPB_BYTE     = 8'h03;
    localparam logic [1:0] EPB_ZERO_RUN = 2'd2;

    // Next zero-run after a byte leaves the classifier. Any non-zero byte
    // (including a dropped 0x03) clears the run; zeros saturate at two.
    function automatic logic [1:0] nextZeroRun(input logic [1:0] zeroRun,
                                               input logic [7:0] dataByte);
        if (dataByte != 8'h00) begin
            return 2'd0;
        end else if (zeroRun >= EPB_ZERO_RUN) begin
            return EPB_ZERO_RUN;
        end else begin
            return zeroRun + 2'd1;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/qdec_byte_slice.sv
`default_nettype none
// ============================================================================
// Module   : qdec_byte_slice
// Brief    : One-entry valid/ready register for the clean byte stream
// Revision : 1.0 - initial release
// ============================================================================
module qdec_byte_slice (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic [7:0] i_byte,
    input  logic       i_last,
    input  logic       i_vld,
    output logic       o_rdy,
    output logic [7:0] o_byte,
    output logic       o_last,
    output logic       o_vld,
    input  logic       i_rdy
);

    logic       r_vld;
    logic [7:0] r_byte;
    logic       r_last;

    // Can take a new byte when empty or when the held byte is being drained
    assign o_rdy  = !r_vld | i_rdy;
    assign o_byte = r_byte;
    assign o_last = r_last;
    assign o_vld  = r_vld;

    // Load on upstream push, otherwise drop valid once the consumer takes it
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_vld  <= 1'b0;
            r_byte <= 8'h00;
            r_last <= 1'b0;
        end else if (i_vld) begin
            r_vld  <= 1'b1;
            r_byte <= i_byte;
            r_last <= i_last;
        end else if (i_rdy) begin
            r_vld  <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/qdec_epb_remover.sv
`default_nettype none
// ============================================================================
// Module   : qdec_epb_remover
// Brief    : Splits NAL payload words into bytes, strips emulation-prevention
//            bytes and streams clean bytes with per-slice counters
// Revision : 1.0 - initial release
// ============================================================================
module qdec_epb_remover
    import qdec_cabac_package::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [31:0] word_in,
    input  logic        word_in_vld,
    output logic        word_in_rdy,
    input  logic        word_in_last,
    input  logic [2:0]  word_in_nbytes,
    output logic [7:0]  byte_out,
    output logic        byte_out_vld,
    input  logic        byte_out_rdy,
    output logic        byte_out_last,
    output logic        epb_removed,
    output logic [15:0] epb_count,
    output logic [23:0] byte_count
);

    // Word buffer
    logic        r_bufVld;
    logic [31:0] r_bufWord;
    logic [1:0]  r_idx;
    logic [2:0]  r_nb;
    logic        r_bufLast;

    // Pending stage: holds the most recent kept byte so last can be attached
    logic        r_pendVld;
    logic [7:0]  r_pendByte;
    logic        r_pendLast;

    logic [1:0]  r_zeroRun;
    logic        r_epbRemoved;
    logic [15:0] r_epbCount;
    logic [23:0] r_byteCount;

    logic [7:0]  w_curByte;
    logic        w_lastIdx;
    logic        w_finalByte;
    logic        w_drop;
    logic        w_sliceRdy;
    logic        w_adv;
    logic        w_keep;
    logic        w_dropEv;
    logic        w_pendToOut;
    logic        w_outLast;
    logic        w_accept;
    logic [2:0]  w_nbIn;

    // Big-endian byte select from the buffered word
    always_comb begin
        w_curByte = r_bufWord[31:24];
        case (r_idx)
            2'd0:    w_curByte = r_bufWord[31:24];
            2'd1:    w_curByte = r_bufWord[23:16];
            2'd2:    w_curByte = r_bufWord[15:8];
            default: w_curByte = r_bufWord[7:0];
        endcase
    end

    assign w_lastIdx   = ({1'b0, r_idx} == (r_nb - 3'd1));
    assign w_finalByte = r_bufLast & w_lastIdx;
    assign w_drop      = (w_curByte == EPB_BYTE) & (r_zeroRun == EPB_ZERO_RUN);

    // Classifier moves only when the pending stage has somewhere to go
    assign w_adv    = r_bufVld & (!r_pendVld | w_sliceRdy);
    assign w_keep   = w_adv & !w_drop;
    assign w_dropEv = w_adv & w_drop;

    // Pending byte leaves when it is final, displaced by a new kept byte,
    // or when the NAL's final byte was an EPB and it must carry last
    assign w_pendToOut = r_pendVld & w_sliceRdy &
                         (r_pendLast | w_keep | (w_dropEv & w_finalByte));
    assign w_outLast   = r_pendLast | (w_dropEv & w_finalByte);

    assign word_in_rdy = rst_n & !flush & (!r_bufVld | (w_adv & w_lastIdx));
    assign w_accept    = word_in_vld & word_in_rdy;

    // Out-of-range byte counts on a last word fall back to a full word
    assign w_nbIn = (!word_in_last || word_in_nbytes == 3'd0 || word_in_nbytes > 3'd4)
                    ? 3'd4 : word_in_nbytes;

    // Word buffer: load on handshake, otherwise step through the bytes
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_bufVld  <= 1'b0;
            r_bufWord <= 32'h0;
            r_idx     <= 2'd0;
            r_nb      <= 3'd4;
            r_bufLast <= 1'b0;
        end else if (w_accept) begin
            r_bufVld  <= 1'b1;
            r_bufWord <= word_in;
            r_idx     <= 2'd0;
            r_nb      <= w_nbIn;
            r_bufLast <= word_in_last;
        end else if (w_adv) begin
            if (w_lastIdx) begin
                r_bufVld <= 1'b0;
            end else begin
                r_idx <= r_idx + 2'd1;
            end
        end
    end

    // Pending stage: capture kept bytes, empty when the byte moves onward
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_pendVld  <= 1'b0;
            r_pendByte <= 8'h00;
            r_pendLast <= 1'b0;
        end else if (w_keep) begin
            r_pendVld  <= 1'b1;
            r_pendByte <= w_curByte;
            r_pendLast <= w_finalByte;
        end else if (w_pendToOut) begin
            r_pendVld  <= 1'b0;
            r_pendLast <= 1'b0;
        end
    end

    // Zero-run tracker; a NAL's last byte restarts the run for the next NAL
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_zeroRun <= 2'd0;
        end else if (w_adv) begin
            r_zeroRun <= w_finalByte ? 2'd0 : nextZeroRun(r_zeroRun, w_curByte);
        end
    end

    // EPB pulse and saturating per-slice counters
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_epbRemoved <= 1'b0;
            r_epbCount   <= 16'h0;
            r_byteCount  <= 24'h0;
        end else begin
            r_epbRemoved <= w_dropEv;
            if (w_dropEv && r_epbCount != 16'hFFFF) begin
                r_epbCount <= r_epbCount + 16'd1;
            end
            if (byte_out_vld && byte_out_rdy && r_byteCount != 24'hFFFFFF) begin
                r_byteCount <= r_byteCount + 24'd1;
            end
        end
    end

    assign epb_removed = r_epbRemoved;
    assign epb_count   = r_epbCount;
    assign byte_count  = r_byteCount;

    qdec_byte_slice u_slice (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .i_byte (r_pendByte),
        .i_last (w_outLast),
        .i_vld  (w_pendToOut),
        .o_rdy  (w_sliceRdy),
        .o_byte (byte_out),
        .o_last (byte_out_last),
        .o_vld  (byte_out_vld),
        .i_rdy  (byte_out_rdy)
    );

endmodule
`default_nettype wire

// File: tb/tb_qdec_epb_remover.sv
`default_nettype none
// ============================================================================
// Module   : tb_qdec_epb_remover
// Brief    : Self-checking bench for qdec_epb_remover
// Revision : 1.0 - initial release
// ============================================================================
module tb_qdec_epb_remover;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [31:0] word_in;
    logic        word_in_vld;
    logic        word_in_rdy;
    logic        word_in_last;
    logic [2:0]  word_in_nbytes;
    logic [7:0]  byte_out;
    logic        byte_out_vld;
    logic        byte_out_rdy;
    logic        byte_out_last;
    logic        epb_removed;
    logic [15:0] epb_count;
    logic [23:0] byte_count;

    qdec_epb_remover dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .word_in        (word_in),
        .word_in_vld    (word_in_vld),
        .word_in_rdy    (word_in_rdy),
        .word_in_last   (word_in_last),
        .word_in_nbytes (word_in_nbytes),
        .byte_out       (byte_out),
        .byte_out_vld   (byte_out_vld),
        .byte_out_rdy   (byte_out_rdy),
        .byte_out_last  (byte_out_last),
        .epb_removed    (epb_removed),
        .epb_count      (epb_count),
        .byte_count     (byte_count)
    );

    typedef struct {
        logic [31:0] word;
        logic        last;
        logic [2:0]  nb;
        int          nExp;
        logic [31:0] expBytes;   // kept bytes, first one in [31:24]
        int          epbs;
    } vec_t;

    vec_t        vecs[10];
    logic [8:0]  expQ[$];        // {last, byte}
    int          hsCycle[$];
    int          compared = 0;
    int          mismatched = 0;
    int          cycle = 0;
    int          accCycle = 0;
    int          tStart = 0;
    int          epbPulses = 0;
    int          expByteTot = 0;
    int          expEpbTot = 0;
    int          rdyMode = 0;
    logic [8:0]  e;
    logic [31:0] tmp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    // Alternating ready when requested
    always @(posedge clk) begin
        #1;
        if (rdyMode == 1) byte_out_rdy = ~byte_out_rdy;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard side: pop on handshake, check held value during stalls
    always @(negedge clk) begin
        if (rst_n) begin
            if (epb_removed) epbPulses++;
            if (byte_out_vld && byte_out_rdy) begin
                hsCycle.push_back(cycle);
                if (expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_byte: got %02h, expected no output", byte_out);
                end else begin
                    e = expQ.pop_front();
                    check("byte_out", {24'h0, byte_out}, {24'h0, e[7:0]});
                    check("byte_out_last", {31'h0, byte_out_last}, {31'h0, e[8]});
                end
            end else if (byte_out_vld && expQ.size() != 0) begin
                check("stall_byte", {24'h0, byte_out}, {24'h0, expQ[0][7:0]});
            end
        end
    end

    // Present a word and hold it until accepted; entered just after a rising edge
    task automatic sendWord(input logic [31:0] w, input logic l, input logic [2:0] nb);
        logic accepted;
        accepted       = 1'b0;
        word_in        = w;
        word_in_last   = l;
        word_in_nbytes = nb;
        word_in_vld    = 1'b1;
        for (int i = 0; i < 200 && !accepted; i++) begin
            @(negedge clk);
            accepted = word_in_rdy;
            @(posedge clk);
            #1;
        end
        word_in_vld = 1'b0;
        accCycle    = cycle;
        if (!accepted) begin
            compared++;
            mismatched++;
            $display("FAIL word_accept_timeout: word %08h not accepted, required acceptance", w);
        end
    endtask

    task automatic pushExp(input int n, input logic [31:0] bytesPacked, input logic last);
        for (int k = 0; k < n; k++) begin
            tmp = bytesPacked << (8 * k);
            expQ.push_back({last && (k == n - 1), tmp[31:24]});
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (expQ.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain_timeout: %0d bytes outstanding, required 0", expQ.size());
            expQ.delete();
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkCounters(input string tag);
        check({tag, "_byte_count"}, {8'h0, byte_count}, expByteTot);
        check({tag, "_epb_count"}, {16'h0, epb_count}, expEpbTot);
        check({tag, "_epb_pulses"}, epbPulses, expEpbTot);
    endtask

    initial begin
        int n;
        vecs[0] = '{32'h11223344, 1'b0, 3'd1, 4, 32'h11223344, 0};  // nb ignored when not last
        vecs[1] = '{32'h556677AA, 1'b1, 3'd4, 4, 32'h556677AA, 0};
        vecs[2] = '{32'h00000301, 1'b1, 3'd4, 3, 32'h00000100, 1};
        vecs[3] = '{32'h12340000, 1'b0, 3'd4, 4, 32'h12340000, 0};
        vecs[4] = '{32'h03FF0000, 1'b1, 3'd4, 3, 32'hFF000000, 1};  // EPB across boundary
        vecs[5] = '{32'hAB000003, 1'b1, 3'd4, 3, 32'hAB000000, 1};  // trailing EPB
        vecs[6] = '{32'h12345678, 1'b1, 3'd2, 2, 32'h12340000, 0};
        vecs[7] = '{32'h00000003, 1'b1, 3'd4, 3, 32'h00000000, 1};  // run saturates at two
        vecs[8] = '{32'h00000303, 1'b1, 3'd4, 3, 32'h00000300, 1};  // second 03 kept
        vecs[9] = '{32'h00AAAAAA, 1'b1, 3'd1, 1, 32'h00000000, 0};

        rst_n          = 1'b0;
        flush          = 1'b0;
        word_in        = 32'h0;
        word_in_vld    = 1'b0;
        word_in_last   = 1'b0;
        word_in_nbytes = 3'd4;
        byte_out_rdy   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        @(negedge clk);
        check("reset_byte_out", {24'h0, byte_out}, 32'h0);
        check("reset_vld", {31'h0, byte_out_vld}, 32'h0);
        check("reset_last", {31'h0, byte_out_last}, 32'h0);
        check("reset_epb_removed", {31'h0, epb_removed}, 32'h0);
        check("reset_epb_count", {16'h0, epb_count}, 32'h0);
        check("reset_byte_count", {8'h0, byte_count}, 32'h0);
        check("reset_word_in_rdy", {31'h0, word_in_rdy}, 32'h1);
        @(posedge clk);
        #1;

        // Table-driven NALs, back-to-back within a NAL, ready held high
        for (int i = 0; i < 10; i++) begin
            pushExp(vecs[i].nExp, vecs[i].expBytes, vecs[i].last);
            if (i == 0) hsCycle.delete();
            sendWord(vecs[i].word, vecs[i].last, vecs[i].nb);
            if (i == 0) tStart = accCycle;
            expByteTot += vecs[i].nExp;
            expEpbTot  += vecs[i].epbs;
            if (vecs[i].last) begin
                waitDrain();
                checkCounters($sformatf("vec%0d", i));
                if (i == 1) begin
                    check("hs_count", hsCycle.size(), 8);
                    if (hsCycle.size() >= 8) begin
                        check("first_byte_latency", hsCycle[0], tStart + 2);
                        check("eighth_byte_no_bubble", hsCycle[7], tStart + 9);
                    end
                end
            end
        end

        // Alternating ready across three words
        rdyMode = 1;
        pushExp(4, 32'h01020304, 1'b0);
        sendWord(32'h01020304, 1'b0, 3'd4);
        pushExp(3, 32'h00000500, 1'b0);
        sendWord(32'h00000305, 1'b0, 3'd4);
        pushExp(4, 32'hA0B0C0D0, 1'b1);
        sendWord(32'hA0B0C0D0, 1'b1, 3'd4);
        expByteTot += 11;
        expEpbTot  += 1;
        waitDrain();
        rdyMode      = 0;
        byte_out_rdy = 1'b1;
        @(posedge clk);
        #1;
        checkCounters("toggle");

        // Flush while a byte is stalled, with a zero run of two built up
        byte_out_rdy = 1'b0;
        pushExp(4, 32'h00000000, 1'b0);
        sendWord(32'h00000000, 1'b0, 3'd4);
        n = 0;
        while (!byte_out_vld && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("stall_vld", {31'h0, byte_out_vld}, 32'h1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(negedge clk);
        check("flush_word_in_rdy", {31'h0, word_in_rdy}, 32'h0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        expQ.delete();
        @(negedge clk);
        check("flush_vld", {31'h0, byte_out_vld}, 32'h0);
        check("flush_byte_count", {8'h0, byte_count}, 32'h0);
        check("flush_epb_count", {16'h0, epb_count}, 32'h0);
        @(posedge clk);
        #1;
        byte_out_rdy = 1'b1;
        epbPulses    = 0;
        expByteTot   = 1;
        expEpbTot    = 0;
        pushExp(1, 32'h03000000, 1'b1);
        sendWord(32'h03000000, 1'b1, 3'd1);
        waitDrain();
        checkCounters("post_flush");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #400000;
        mismatched++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/qdec_epb_remover.md
# qdec_epb_remover

Front end of the CABAC slice-data path. It accepts 32-bit NAL payload words from the bitstream DMA and splits them into bytes. It strips H.265 emulation-prevention bytes: a 0x03 that follows two consecutive 0x00 bytes. It then streams the clean bytes, one per cycle, into the arithmetic decoder's `bitstreamFetch` valid/ready port. It also keeps per-slice byte and EPB counters, which the slice controller uses for `end_of_slice_segment` and entry-point accounting.

## Interface
- No parameters.
- `clk` in 1 — clock.
- `rst_n` in 1 — reset, synchronous, active-low.
- `flush` in 1 — single-cycle pulse at slice start; clears all datapath state and counters.
- `word_in` in 32 — payload word, big-endian: [31:24] is the first byte.
- `word_in_vld` in 1 — word valid.
- `word_in_rdy` out 1 — word accepted on a cycle with `vld & rdy`.
- `word_in_last` in 1 — last word of the NAL.
- `word_in_nbytes` in 3 — valid bytes, 1..4, taken from the MSB side; sampled only with `word_in_last`, otherwise treated as 4.
- `byte_out` out 8 — clean byte; drives the decoder's `bitstreamFetch`.
- `byte_out_vld` out 1 — byte valid.
- `byte_out_rdy` in 1 — decoder ready (`bitstreamFetch_rdy`).
- `byte_out_last` out 1 — marks the final kept byte of the NAL.
- `epb_removed` out 1 — one-cycle pulse for each dropped EPB.
- `epb_count` out 16 — EPBs dropped since flush; saturates at 0xFFFF.
- `byte_count` out 24 — bytes handed off (`vld & rdy`) since flush; saturates.

## Operation
- Reset or `flush` clears the word buffer, the pending stage, the output register, `zero_run` and both counters.
- Output reset values: `byte_out` = 0, `byte_out_vld` = 0, `byte_out_last` = 0, `epb_removed` = 0, counters = 0.
- `word_in_rdy` reads 1 from the first cycle after reset and is 0 in the `flush` cycle. A word presented during `flush` is not accepted.
- Word buffer: holds one word plus byte index `idx` (0..3) and `nb` (valid byte count).
- `word_in_rdy` is combinational: `!buf_vld | (advance & idx == nb-1)`. This allows back-to-back words at 1 byte/cycle.
- Classifier, one byte per `advance` cycle:
  - byte == 0x03 and `zero_run` == 2 → drop; `zero_run` ← 0; pulse `epb_removed`.
  - byte == 0x00 → keep; `zero_run` ← min(`zero_run` + 1, 2).
  - otherwise → keep; `zero_run` ← 0.
- `zero_run` carries across word boundaries and resets after the NAL's last byte. The 0x03 is dropped regardless of the byte that follows it.
- Pending stage: a one-byte hold between classifier and output register, so `last` can be attached after a trailing EPB.
  - Kept, non-final byte: the pending byte moves to the output register and the new byte enters pending.
  - Final NAL byte kept: the pending byte goes out, then the final byte follows with `byte_out_last` = 1.
  - Final NAL byte dropped: the pending byte is emitted with `byte_out_last` = 1.
  - A NAL with zero kept bytes (a single 0x03 cannot reach `zero_run` 2, so this never occurs) needs no handling.
- `advance` = `buf_vld & (pending stage can accept)`. The pending stage can accept when it is empty or the output register is empty or being drained (`!byte_out_vld | byte_out_rdy`).
- Output register holds its value stable while `vld & !rdy`.

## Timing
- Throughput: 1 byte/cycle sustained while `byte_out_rdy` = 1. Each dropped EPB costs one bubble.
- Latency: for a word accepted at edge T, byte 0 is visible on `byte_out` after edge T+2. Byte k follows at T+2+k when nothing stalls or is dropped.
- Final byte: appears at most 2 cycles after classification.
- Backpressure: `byte_out_rdy` low freezes output, pending stage and classifier in the same cycle. `word_in_rdy` falls combinationally.
- `flush` while output is stalled: `byte_out_vld` drops after the flush edge and the held byte is discarded.
- Counters update on the edge after the event. `byte_count` counts handshakes, not classifications.

## Structure
- `qdec_cabac_package` adds `EPB_BYTE` = 8'h03 and `EPB_ZERO_RUN` = 2.
- One natural sub-module, `qdec_byte_slice`: a one-entry valid/ready register holding `byte_out`/`byte_out_last`.
- The classifier and word buffer stay in the top module.

## Test plan
- Words 0x11223344, 0x556677AA (last, nb = 4), `rdy` held 1 → bytes 11..AA in order. `last` on AA. 8 cycles with no bubble after T+2. `epb_count` = 0.
- Word 0x00000301 (last) → output 00, 00, 01. `epb_removed` pulses once. `epb_count` = 1. `byte_count` = 3.
- EPB across a boundary: 0x12340000, then 0x03FF0000 (last) → 12, 34, 00, 00, FF, 00, 00. The 03 is dropped.
- Trailing EPB: 0xAB000003 (last, nb = 4) → AB, 00, 00, with `byte_out_last` on the second 00.
- `byte_out_rdy` toggled 1/0 every cycle over 3 words → order preserved, no loss or duplication. `byte_out` stable during stalls.
- `flush` asserted while a byte is stalled mid-word → `byte_out_vld` = 0 and counters = 0 next cycle. A new word then restarts with `zero_run` = 0: input 0x03 is kept.
